// File: rtl/acq_address_generator.sv
// Free-running BRAM address sweep with a wrap-aligned, software-armed single-frame capture.
// Optional macro EXT_TRIGGER_EN adds ext_trig gating of the ARMED -> CAPTURE transition.
module acq_address_generator #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned ADDR_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
`ifdef EXT_TRIGGER_EN
    input  logic                  ext_trig,
`endif
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  start_acq,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frame_count
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  start_prev;
    logic                  start_req;
    logic                  wrap;
    logic                  cnt_last;
    logic                  trig_ok;
    logic                  sop;
    logic                  sop_r;
    logic [ADDR_WIDTH-1:0] addr_pipe [ADDR_DELAY];
    logic [ADDR_DELAY-1:0] sop_pipe;

    assign start_req = start & ~start_prev;
    assign wrap      = (counter == '1);
    assign cnt_last  = (cnt == '1);

`ifdef EXT_TRIGGER_EN
    logic trig_prev;
    logic trig_seen;

    // Only an edge seen while already ARMED counts; the wrap test uses the registered flag,
    // so an edge coinciding with the wrap defers capture to the next wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            trig_prev <= 1'b0;
            trig_seen <= 1'b0;
        end else begin
            trig_prev <= ext_trig;
            if (state == ARMED && next_state != CAPTURE)
                trig_seen <= trig_seen | (ext_trig & ~trig_prev);
            else
                trig_seen <= 1'b0;
        end
    end

    assign trig_ok = trig_seen;
`else
    assign trig_ok = 1'b1;
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            counter     <= '0;
            cnt         <= '0;
            start_prev  <= 1'b0;
            sop_r       <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= next_state;
            counter    <= counter + 1'b1;
            start_prev <= start;
            sop_r      <= sop;
            if (state == CAPTURE)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (state == CAPTURE && cnt_last)
                frame_count <= frame_count + 32'd1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_req)       next_state = ARMED;
            ARMED:   if (wrap && trig_ok) next_state = CAPTURE;
            CAPTURE: if (cnt_last)        next_state = DONE;
            DONE:    if (start_req)       next_state = ARMED;
            default:                      next_state = IDLE;
        endcase
    end

    // Output decode; busy/done come straight from the state register
    always_comb begin
        busy = (state == ARMED) || (state == CAPTURE);
        done = (state == DONE);
        sop  = (state == ARMED) && (next_state == CAPTURE);
    end

    // sop_r lines up with counter==0; delaying both by ADDR_DELAY keeps start_acq on address==0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ADDR_DELAY; i++)
                addr_pipe[i] <= '0;
            sop_pipe <= '0;
        end else begin
            addr_pipe[0] <= counter;
            sop_pipe[0]  <= sop_r;
            for (int unsigned i = 1; i < ADDR_DELAY; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
                sop_pipe[i]  <= sop_pipe[i-1];
            end
        end
    end

    assign address   = addr_pipe[ADDR_DELAY-1];
    assign start_acq = sop_pipe[ADDR_DELAY-1];

endmodule

// File: tb/tb_acq_address_generator.sv
// Scoreboard bench for acq_address_generator: two instances (ADDR_DELAY 1 and 3) share stimulus
// and are compared against a time-based reference model.
module tb_acq_address_generator;

    localparam int M = 16;
`ifdef EXT_TRIGGER_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        ext_trig;
    logic [3:0]  address1, address3;
    logic        start_acq1, start_acq3;
    logic        busy1, busy3;
    logic        done1, done3;
    logic [31:0] fc1, fc3;

    always #5 clk = ~clk;

    acq_address_generator #(.ADDR_WIDTH(4), .ADDR_DELAY(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start),
`ifdef EXT_TRIGGER_EN
        .ext_trig(ext_trig),
`endif
        .address(address1), .start_acq(start_acq1), .busy(busy1), .done(done1), .frame_count(fc1)
    );

    acq_address_generator #(.ADDR_WIDTH(4), .ADDR_DELAY(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start),
`ifdef EXT_TRIGGER_EN
        .ext_trig(ext_trig),
`endif
        .address(address3), .start_acq(start_acq3), .busy(busy3), .done(done3), .frame_count(fc3)
    );

    typedef struct {
        logic [3:0]  a1;
        logic        s1;
        logic [3:0]  a3;
        logic        s3;
        logic        busy;
        logic        done;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: time n counts cycles since reset; capture starts are kept as times.
    int          n = 0;
    bit          armed, capturing, dn, start_prev, trig_prev, trig_seen;
    logic [31:0] frames = '0;
    int          sops[$];
    bit          cur_start = 0, cur_trig = 0;

    function automatic logic [3:0] addr_at(int d);
        int v;
        v = (n >= d) ? ((n - d) % M) : 0;
        return v[3:0];
    endfunction

    function automatic logic sop_at(int d);
        foreach (sops[i]) if (sops[i] == n - d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit st, input bit tr);
        bit   req, tedge, wrap;
        exp_t e;
        @(negedge clk);
        resetn = rst_n; start = st; ext_trig = tr;
        cur_start = st; cur_trig = tr;
        if (!rst_n) begin
            n = 0; armed = 0; capturing = 0; dn = 0; frames = '0;
            start_prev = 0; trig_prev = 0; trig_seen = 0;
            sops.delete();
        end else begin
            req   = st && !start_prev;
            tedge = tr && !trig_prev;
            wrap  = (n % M) == M - 1;
            if (capturing) begin
                if (wrap) begin capturing = 0; dn = 1; frames = frames + 1; end
            end else if (armed) begin
                if (wrap && (!EXT || trig_seen)) begin
                    armed = 0; capturing = 1; trig_seen = 0; sops.push_back(n + 1);
                end else if (tedge) trig_seen = 1;
            end else if (req) begin
                armed = 1; dn = 0;
            end
            start_prev = st; trig_prev = tr; n++;
            while (sops.size() > 0 && sops[0] < n - 10) void'(sops.pop_front());
        end
        e.a1 = addr_at(1); e.s1 = sop_at(1);
        e.a3 = addr_at(3); e.s3 = sop_at(3);
        e.busy = armed || capturing; e.done = dn; e.fc = frames;
        sb.push_back(e);
    endtask

    task automatic hold(input int k);
        repeat (k) step(1, cur_start, cur_trig);
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < M && (n % M) != v; i++) step(1, cur_start, cur_trig);
    endtask

    task automatic wait_capture();
        for (int i = 0; i < 3 * M && !capturing; i++) step(1, cur_start, cur_trig);
    endtask

    // Monitor: every cycle the DUTs present outputs; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("address_d1", 32'(address1), 32'(e.a1));
                check("start_acq_d1", 32'(start_acq1), 32'(e.s1));
                check("address_d3", 32'(address3), 32'(e.a3));
                check("start_acq_d3", 32'(start_acq3), 32'(e.s3));
                check("busy_d1", 32'(busy1), 32'(e.busy));
                check("busy_d3", 32'(busy3), 32'(e.busy));
                check("done_d1", 32'(done1), 32'(e.done));
                check("done_d3", 32'(done3), 32'(e.done));
                check("frame_count_d1", fc1, e.fc);
                check("frame_count_d3", fc3, e.fc);
            end
        end
    end

    initial begin
        resetn = 1'b0; start = 1'b0; ext_trig = 1'b0;
        repeat (3) step(0, 0, 0);
        hold(20);

        // single frame, start at counter 5, start held high through DONE
        wait_cnt(5); step(1, 1, 0);
`ifdef EXT_TRIGGER_EN
        hold(5); step(1, 1, 1); step(1, 1, 0);
`endif
        hold(60);
        // drop and raise: second frame; a fresh edge during capture is ignored
        step(1, 0, 0); step(1, 1, 0);
`ifdef EXT_TRIGGER_EN
        hold(3); step(1, 1, 1); step(1, 1, 0);
`endif
        wait_capture(); hold(4);
        step(1, 0, 0); step(1, 1, 0);
        hold(40); step(1, 0, 0);

        // start edge exactly on the wrap
        wait_cnt(15); step(1, 1, 0); step(1, 0, 0);
`ifdef EXT_TRIGGER_EN
        hold(4); step(1, 0, 1); step(1, 0, 0);
`endif
        hold(40);

        // reset in the middle of a capture
        step(1, 1, 0); step(1, 0, 0);
`ifdef EXT_TRIGGER_EN
        hold(2); step(1, 0, 1); step(1, 0, 0);
`endif
        wait_capture(); wait_cnt(7);
        step(0, 0, 0); step(0, 0, 0);
        hold(20);

`ifdef EXT_TRIGGER_EN
        // armed with no trigger, then trigger at counter 9; then trigger edge on the wrap
        step(1, 1, 0); step(1, 0, 0);
        hold(40);
        wait_cnt(9); step(1, 0, 1); step(1, 0, 0);
        hold(40);
        step(1, 1, 0); step(1, 0, 0);
        wait_cnt(15); step(1, 0, 1); step(1, 0, 0);
        hold(40);
`endif

        // randomized traffic
        for (int i = 0; i < 1200; i++) begin
            bit r, s, t;
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 7) == 0) ? !cur_start : cur_start;
            t = ($urandom_range(0, 5) == 0) ? !cur_trig : cur_trig;
            step(r, s, t);
        end
        hold(5);

        @(posedge clk); #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
